// File: rtl/result_monitor_if.sv
// Result monitor bus: run/enable/pass flags in,
// qualified pass, sticky failures and heartbeat out.
interface result_monitor_if #(
  parameter int NUM_CH    = 2,
  parameter int ERR_CNT_W = 16
);
  logic                 run;
  logic                 enable;
  logic [NUM_CH-1:0]    pass_in;
  logic                 pass_out;
  logic                 valid_out;
  logic [NUM_CH-1:0]    fail_mask;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 hb_out;

  modport master (
    output run, enable, pass_in,
    input  pass_out, valid_out, fail_mask,
    input  err_count, hb_out
  );

  modport slave (
    input  run, enable, pass_in,
    output pass_out, valid_out, fail_mask,
    output err_count, hb_out
  );
endinterface

// File: rtl/result_monitor.sv
// Downstream checker for the BRAM power-test pair:
// masks pipeline fill, latches sticky failures, drives heartbeat.
module result_monitor #(
  parameter int NUM_CH        = 2,
  parameter int SETTLE_CYCLES = 16,
  parameter int ERR_CNT_W     = 16,
  parameter int HB_DIV_LOG2   = 24
) (
  input  logic           clk,
  input  logic           rst,
  result_monitor_if.slave bus
);

  localparam int SET_W =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_MON,
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [SET_W-1:0]       set_cnt_q, set_cnt_d;
  logic [HB_DIV_LOG2-1:0] hb_cnt_q, hb_cnt_d;
  logic                   hb_q, hb_d;
  logic [NUM_CH-1:0]      fail_q, fail_d;
  logic [ERR_CNT_W-1:0]   err_q, err_d;
  logic                   valid_q, valid_d;
  logic                   pass_q, pass_d;
  logic                   hbo_q, hbo_d;

  // State and result registers; enable=0 leaves every _d equal to _q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      set_cnt_q <= '0;
      hb_cnt_q  <= '0;
      hb_q      <= 1'b0;
      fail_q    <= '0;
      err_q     <= '0;
      valid_q   <= 1'b0;
      pass_q    <= 1'b0;
      hbo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      set_cnt_q <= set_cnt_d;
      hb_cnt_q  <= hb_cnt_d;
      hb_q      <= hb_d;
      fail_q    <= fail_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      pass_q    <= pass_d;
      hbo_q     <= hbo_d;
    end
  end

  // Next-state, sampling and output qualification
  always_comb begin
    state_d   = state_q;
    set_cnt_d = set_cnt_q;
    hb_cnt_d  = hb_cnt_q;
    hb_d      = hb_q;
    fail_d    = fail_q;
    err_d     = err_q;
    valid_d   = valid_q;
    if (bus.enable) begin
      unique case (state_q)
        S_IDLE, S_STOP: begin
          if (bus.run) begin
            state_d   = S_SETTLE;
            set_cnt_d = '0;
            hb_cnt_d  = '0;
            hb_d      = 1'b0;
            fail_d    = '0;
            err_d     = '0;
            valid_d   = 1'b0;
          end
        end
        S_SETTLE: begin
          if (!bus.run) begin
            state_d   = S_IDLE;
            set_cnt_d = '0;
          end else begin
            set_cnt_d = set_cnt_q + 1'b1;
            if (set_cnt_q == SET_W'(SETTLE_CYCLES - 1))
              state_d = S_MON;
          end
        end
        S_MON: begin
          hb_cnt_d = hb_cnt_q + 1'b1;
          if (&hb_cnt_q)
            hb_d = ~hb_q;
          if (bus.run) begin
            valid_d = 1'b1;
            fail_d  = fail_q | ~bus.pass_in;
            if (!(&bus.pass_in) && !(&err_q))
              err_d = err_q + 1'b1;
          end else begin
            state_d = S_STOP;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    pass_d = valid_d & ~|fail_d;
    hbo_d  = ((state_d == S_MON) || (state_d == S_STOP))
           & (hb_d | (|fail_d));
  end

  assign bus.pass_out  = pass_q;
  assign bus.valid_out = valid_q;
  assign bus.fail_mask = fail_q;
  assign bus.err_count = err_q;
  assign bus.hb_out    = hbo_q;

endmodule

// File: doc/result_monitor.md
Name: result_monitor

Overview:
- Downstream checker for the BRAM power-test pair; consumes the per-instance pass flags and the gated start/enable controls.
- Masks the pipeline-fill window after each start, then samples every enabled cycle and latches sticky per-channel failures with a saturating error count.
- Produces a qualified pass output and a heartbeat/fail indicator for the FMC/LED pins.

Parameters:
- NUM_CH, 2, number of pass channels monitored (>=1).
- SETTLE_CYCLES, 16, enabled cycles ignored after start before sampling begins (>=1).
- ERR_CNT_W, 16, width of the saturating error counter.
- HB_DIV_LOG2, 24, heartbeat toggles every 2^HB_DIV_LOG2 enabled cycles.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  asynchronous active-high reset.
- run  in  1  start & !stop from the top level; level-sensitive.
- enable  in  1  clock enable shared with the BRAM blocks; 0 freezes all state.
- pass_in  in  NUM_CH  per-instance pass flags, bit i = channel i.
- pass_out  out  1  1 = results valid and no channel ever failed.
- valid_out  out  1  1 = at least one sample taken since the last start.
- fail_mask  out  NUM_CH  sticky per-channel failure bits.
- err_count  out  ERR_CNT_W  cycles with any failing channel, saturating.
- hb_out  out  1  heartbeat/fail indicator.

Behaviour:
- Reset (async assert, released synchronously by the upstream reset logic): state=IDLE; pass_out=0, valid_out=0, fail_mask=0, err_count=0, hb_out=0; settle and heartbeat counters=0.
- States: IDLE, SETTLE, MONITOR, STOPPED. All transitions and updates occur only when enable=1; with enable=0, state, counters and outputs hold.
- IDLE: if run=1, go to SETTLE. On entry clear fail_mask, err_count, valid_out, settle counter and heartbeat counter.
- SETTLE: settle counter increments each enabled cycle; pass_in is ignored.
  - When run=1 and the counter reaches SETTLE_CYCLES-1, go to MONITOR on the next edge. First sample occurs in the cycle after SETTLE_CYCLES enabled SETTLE cycles.
  - If run=0, go to IDLE. Partial results are discarded; valid_out stays 0.
- MONITOR, run=1: sample pass_in each enabled cycle.
  - fail_mask |= ~pass_in.
  - If any bit of pass_in is 0, err_count += 1, saturating at 2^ERR_CNT_W-1 (no wrap).
  - valid_out is set to 1 on the first sample.
- MONITOR, run=0: no sample that cycle; go to STOPPED.
- STOPPED: fail_mask, err_count and valid_out are frozen. If run=1, go to SETTLE, clearing results as on IDLE exit.
- pass_out = valid_out & ~|fail_mask; registered, same-cycle update as fail_mask.
- hb_out:
  - 0 in IDLE and SETTLE.
  - In MONITOR/STOPPED with fail_mask=0, toggles when the heartbeat counter wraps after 2^HB_DIV_LOG2 enabled cycles; the counter runs only in MONITOR.
  - Forced to 1 once any fail_mask bit is set.
- Run glitch: run low for one enabled cycle in MONITOR causes MONITOR→STOPPED→SETTLE, which restarts with cleared results.
- Reset mid-operation: immediate return to reset values regardless of state or enable.

Test Plan:
- Params NUM_CH=2, SETTLE_CYCLES=4, ERR_CNT_W=4, HB_DIV_LOG2=3. Reset asserted with enable=1, run=1 → all outputs 0. Release reset → SETTLE for 4 cycles, valid_out=1 on cycle 5, pass_out=1 with pass_in=2'b11.
- Drive pass_in=2'b00 during the 4 SETTLE cycles, then 2'b11 → fail_mask=0, err_count=0, pass_out=1.
- In MONITOR, pass_in=2'b10 for 3 cycles → fail_mask=2'b01, err_count=3, pass_out=0, hb_out=1. Then 20 cycles of 2'b01 → err_count saturates at 15, fail_mask=2'b11.
- enable=0 for 10 cycles mid-MONITOR with pass_in=2'b00 → no change to err_count, fail_mask or heartbeat phase. With enable=1 and fail-free operation, hb_out toggles every 8 cycles.
- Drop run in MONITOR after a failure → STOPPED, outputs frozen. Reassert run → fail_mask=0, err_count=0, valid_out=0, and 4-cycle settle repeats.
- Drop run at SETTLE cycle 2 → IDLE, valid_out=0. Assert rst in MONITOR → all outputs 0 within the same cycle.
